// File: rtl/foc_pkg.sv
// Shared FOC datapath definitions: default widths, quarter-turn offset,
// requester id type and the sin/cos scheduler state encoding.
package foc_pkg;
    localparam int          PH_W       = 16;
    localparam int          DW         = 16;
    localparam logic [15:0] COS_OFFSET = 16'h4000;

    typedef logic req_id_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sched_state_t;
endpackage

// File: rtl/sincos_sched_rr_arb2.sv
// Two-way round-robin arbiter; rr names the requester that wins a tie and
// flips to the other requester after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] pend,
    input  logic       enable,
    output logic [1:0] grant
);
    logic rr;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (pend)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr <= 1'b0;
        else if (|grant)
            rr <= grant[0];
    end
endmodule

// File: rtl/sincos_sched.sv
// Shares one sin_lut between the Park (req 0) and inverse Park (req 1) paths:
// each grant looks up sin(ph) then sin(ph + quarter turn) and returns the pair.
module sincos_sched #(
    parameter int              PH_W       = foc_pkg::PH_W,
    parameter int              DW         = foc_pkg::DW,
    parameter int              LUT_LAT    = 1,
    parameter logic [PH_W-1:0] COS_OFFSET = PH_W'(foc_pkg::COS_OFFSET)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             i_req,
    input  logic [PH_W-1:0]        i_ph0,
    input  logic [PH_W-1:0]        i_ph1,
    output logic [PH_W-1:0]        o_lut_ph,
    input  logic signed [DW-1:0]   i_lut_sin,
    output logic signed [DW-1:0]   o_sin,
    output logic signed [DW-1:0]   o_cos,
    output logic [1:0]             o_valid,
    output logic                   o_busy
);
    import foc_pkg::sched_state_t;
    import foc_pkg::req_id_t;
    import foc_pkg::IDLE;
    import foc_pkg::ISSUE;
    import foc_pkg::WAIT;

    localparam int CNT_W = $clog2(LUT_LAT + 2);

    sched_state_t            state, state_nx;
    logic [1:0]              pend;
    logic [1:0][PH_W-1:0]    ph_buf;
    logic [PH_W-1:0]         ph;
    req_id_t                 id;
    logic [CNT_W-1:0]        cnt;
    logic signed [DW-1:0]    sin_cap;
    logic [1:0]              grant;
    logic                    sin_hit;
    logic                    cos_hit;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .pend   (pend),
        .enable (state == IDLE),
        .grant  (grant)
    );

    // A strobe on the grant cycle re-arms pend; the grant itself uses the old buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= '0;
            ph_buf <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (i_req[n])
                    pend[n] <= 1'b1;
                else if (grant[n])
                    pend[n] <= 1'b0;
            end
            if (i_req[0]) ph_buf[0] <= i_ph0;
            if (i_req[1]) ph_buf[1] <= i_ph1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // In WAIT, cnt counts edges since the cosine address went out.
    always_comb begin
        state_nx = state;
        sin_hit  = 1'b0;
        cos_hit  = 1'b0;
        case (state)
            IDLE:    if (|grant) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT: begin
                sin_hit = (cnt == CNT_W'(LUT_LAT - 1));
                cos_hit = (cnt == CNT_W'(LUT_LAT));
                if (cos_hit) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph       <= '0;
            id       <= 1'b0;
            cnt      <= '0;
            sin_cap  <= '0;
            o_lut_ph <= '0;
            o_sin    <= '0;
            o_cos    <= '0;
            o_valid  <= 2'b00;
        end else begin
            o_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        ph       <= grant[1] ? ph_buf[1] : ph_buf[0];
                        o_lut_ph <= grant[1] ? ph_buf[1] : ph_buf[0];
                        id       <= grant[1];
                    end
                end
                ISSUE: begin
                    o_lut_ph <= ph + COS_OFFSET;
                    cnt      <= '0;
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (sin_hit)
                        sin_cap <= i_lut_sin;
                    if (cos_hit) begin
                        o_sin   <= sin_cap;
                        o_cos   <= i_lut_sin;
                        o_valid <= id ? 2'b10 : 2'b01;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (state != IDLE);
endmodule

// File: tb/tb_sincos_sched.sv
// Two schedulers (LUT latency 1 and 4) driven against a transaction-level
// model of grant/issue/return timing and a synthetic LUT.
module tb_sincos_sched;
    localparam logic [15:0] OFF = 16'h4000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         req     [2];
    logic [15:0]        ph0     [2];
    logic [15:0]        ph1     [2];
    logic [15:0]        lut_ph  [2];
    logic signed [15:0] lut_sin [2];
    logic signed [15:0] sin_o   [2];
    logic signed [15:0] cos_o   [2];
    logic [1:0]         valid   [2];
    logic               busy    [2];
    int                 pulses  [2];

    int checks = 0;
    int errors = 0;

    function automatic logic signed [15:0] lut(input logic [15:0] p);
        logic [15:0] m;
        m = p * 16'h9E37;
        return $signed(m ^ (p >> 5));
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 4;

        logic [15:0]        dly [LAT];
        logic [15:0]        e_lut_ph = '0;
        logic signed [15:0] e_sin    = '0;
        logic signed [15:0] e_cos    = '0;
        logic [1:0]         e_valid  = '0;
        logic               e_busy   = 1'b0;

        sincos_sched #(.LUT_LAT(LAT)) dut (
            .clk       (clk),
            .rst       (rst),
            .i_req     (req[g]),
            .i_ph0     (ph0[g]),
            .i_ph1     (ph1[g]),
            .o_lut_ph  (lut_ph[g]),
            .i_lut_sin (lut_sin[g]),
            .o_sin     (sin_o[g]),
            .o_cos     (cos_o[g]),
            .o_valid   (valid[g]),
            .o_busy    (busy[g])
        );

        // LUT: sample for an address appears LAT edges after the address changes
        always @(posedge clk) begin
            dly[0] <= lut_ph[g];
            for (int k = 1; k < LAT; k++) dly[k] <= dly[k-1];
        end
        assign lut_sin[g] = lut(dly[LAT-1]);

        // Reference: edge-numbered transactions; grant G, pair returned at V = G+LAT+2
        initial begin : model
            logic [1:0]  pnd = '0;
            logic [15:0] bf [2];
            logic        rrp = 1'b0;
            logic        w;
            logic        tid = 1'b0;
            logic [15:0] tph = '0;
            int          e = 0;
            int          gg = -100;
            int          vv = -100;
            bf[0] = '0;
            bf[1] = '0;
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    pnd = '0; bf[0] = '0; bf[1] = '0; rrp = 1'b0;
                    e = 0; gg = -100; vv = -100;
                    e_lut_ph = '0; e_sin = '0; e_cos = '0; e_valid = '0; e_busy = 1'b0;
                end else begin
                    e++;
                    if (e > vv && pnd != 2'b00) begin
                        w      = (pnd == 2'b11) ? rrp : pnd[1];
                        rrp    = ~w;
                        pnd[w] = 1'b0;
                        tph    = bf[w];
                        tid    = w;
                        gg     = e;
                        vv     = e + LAT + 2;
                    end
                    if (req[g][0]) begin pnd[0] = 1'b1; bf[0] = ph0[g]; end
                    if (req[g][1]) begin pnd[1] = 1'b1; bf[1] = ph1[g]; end
                    e_valid = 2'b00;
                    if (e == gg)     e_lut_ph = tph;
                    if (e == gg + 1) e_lut_ph = tph + OFF;
                    if (e == vv) begin
                        e_valid = tid ? 2'b10 : 2'b01;
                        e_sin   = lut(tph);
                        e_cos   = lut(tph + OFF);
                    end
                    e_busy = (e >= gg) && (e < vv);
                end
            end
        end

        initial begin : cmp
            int n = 0;
            int last = -1;
            pulses[g] = 0;
            forever begin
                @(negedge clk);
                n++;
                if (rst) last = -1;
                chk($sformatf("d%0d valid", g), 16'(valid[g]), 16'(e_valid));
                chk($sformatf("d%0d lut_ph", g), lut_ph[g], e_lut_ph);
                chk($sformatf("d%0d sin", g), sin_o[g], e_sin);
                chk($sformatf("d%0d cos", g), cos_o[g], e_cos);
                chk($sformatf("d%0d busy", g), 16'(busy[g]), 16'(e_busy));
                if (valid[g] != 2'b00) begin
                    pulses[g]++;
                    if (last >= 0)
                        chk($sformatf("d%0d spacing", g), 16'(n - last >= LAT + 3), 16'd1);
                    last = n;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge: strobe is sampled at the next rising edge.
    task automatic drive(input int d, input logic [1:0] r, input logic [15:0] a, input logic [15:0] b);
        req[d] = r;
        if (r[0]) ph0[d] = a;
        if (r[1]) ph1[d] = b;
        @(negedge clk);
        req[d] = 2'b00;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int p;
        for (int d = 0; d < 2; d++) begin
            req[d] = 2'b00; ph0[d] = '0; ph1[d] = '0;
        end
        #1 rst = 1'b1;
        tick(3);
        chk("reset valid", 16'(valid[0]), 16'h0);
        chk("reset busy", 16'(busy[0]), 16'h0);
        chk("reset sin", sin_o[0], 16'h0);
        chk("reset lut_ph", lut_ph[1], 16'h0);
        rst = 1'b0;
        tick(2);

        drive(0, 2'b01, 16'h0000, 16'h0000);
        tick(1); chk("single sin addr", lut_ph[0], 16'h0000);
                 chk("single busy", 16'(busy[0]), 16'h1);
        tick(1); chk("single cos addr", lut_ph[0], 16'h4000);
        tick(1); chk("single early", 16'(valid[0]), 16'h0);
        tick(1); chk("single valid", 16'(valid[0]), 16'h1);
                 chk("single sin", sin_o[0], 16'h0000);
                 chk("single cos", cos_o[0], 16'hC200);
        tick(2);

        drive(0, 2'b10, 16'h0000, 16'hC000);
        tick(2); chk("wrap cos addr", lut_ph[0], 16'h0000);
        tick(2); chk("wrap valid", 16'(valid[0]), 16'h2);
                 chk("wrap sin", sin_o[0], 16'h4600);
                 chk("wrap cos", cos_o[0], 16'h0000);
        tick(1);

        do_reset();
        drive(0, 2'b11, 16'h1000, 16'h2000);
        tick(2);
        drive(0, 2'b11, 16'h3000, 16'h6000);
        tick(1); chk("both first", 16'(valid[0]), 16'h1);
                 chk("both first sin", sin_o[0], lut(16'h1000));
        tick(4); chk("both second", 16'(valid[0]), 16'h2);
                 chk("both second cos", cos_o[0], lut(16'hA000));
        tick(4); chk("both third", 16'(valid[0]), 16'h1);
        tick(3);
        drive(0, 2'b11, 16'h7000, 16'h8000);
        tick(4); chk("repeat first", 16'(valid[0]), 16'h2);
        tick(4); chk("repeat second", 16'(valid[0]), 16'h1);
        tick(3);

        p = pulses[0];
        drive(0, 2'b01, 16'h1000, 16'h0000);
        tick(2);
        drive(0, 2'b10, 16'h0000, 16'h3000);
        drive(0, 2'b10, 16'h0000, 16'h5000);
        tick(4); chk("overwrite valid", 16'(valid[0]), 16'h2);
                 chk("overwrite sin", sin_o[0], lut(16'h5000));
        tick(6); chk("overwrite pulses", 16'(pulses[0] - p), 16'd2);

        req[0] = 2'b01; req[1] = 2'b01;
        ph0[0] = 16'h2400; ph0[1] = 16'h2400;
        tick(1);
        req[0] = 2'b00; req[1] = 2'b00;
        tick(3);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst d%0d lut_ph", d), lut_ph[d], 16'h0);
            chk($sformatf("rst d%0d sin", d), sin_o[d], 16'h0);
            chk($sformatf("rst d%0d cos", d), cos_o[d], 16'h0);
            chk($sformatf("rst d%0d valid", d), 16'(valid[d]), 16'h0);
            chk($sformatf("rst d%0d busy", d), 16'(busy[d]), 16'h0);
        end
        p = pulses[0] + pulses[1];
        tick(2);
        rst = 1'b0;
        tick(10);
        chk("rst no valid", 16'(pulses[0] + pulses[1] - p), 16'd0);
        drive(0, 2'b01, 16'h2400, 16'h0000);
        tick(4); chk("post rst valid", 16'(valid[0]), 16'h1);
                 chk("post rst sin", sin_o[0], lut(16'h2400));

        for (int i = 0; i < 64; i++) begin
            logic [15:0] ph;
            ph = 16'(i * 16'h0400);
            if (i % 2 == 0) drive(1, 2'b01, ph, 16'h0000);
            else            drive(1, 2'b10, 16'h0000, ph);
            tick($urandom_range(6, 9));
        end
        tick(12);

        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                req[d] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
                ph0[d] = 16'($urandom);
                ph1[d] = 16'($urandom);
            end
            tick(1);
        end
        req[0] = 2'b00; req[1] = 2'b00;
        tick(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sincos_sched.md
# sincos_sched

Time-multiplexes the single shared `sin_lut` between two angle consumers in the FOC datapath: requester 0 is the Park transform and requester 1 is the inverse Park transform. For each granted request it issues the sine address and then the cosine address (phase + 90°) to the LUT. It captures both results and returns them as one sin/cos pair, tagged with the requester. Arbitration between the two requesters is round-robin.

## Interface
Parameters:
- PH_W, 16, phase width; LUT address width.
- DW, 16, signed LUT sample width.
- LUT_LAT, 1, number of clock edges from `o_lut_ph` changing to `i_lut_sin` holding the matching sample. Legal range 1..8.
- COS_OFFSET, 16'h4000, quarter-turn added to the phase for the cosine lookup.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  2  per-requester single-cycle request strobe; bit n belongs to requester n.
- i_ph0  in  PH_W  requester 0 phase, sampled when i_req[0]=1.
- i_ph1  in  PH_W  requester 1 phase, sampled when i_req[1]=1.
- o_lut_ph  out  PH_W  registered phase driven to the shared sin_lut.
- i_lut_sin  in  DW  signed sin_lut output.
- o_sin  out  DW  signed captured sine result.
- o_cos  out  DW  signed captured cosine result.
- o_valid  out  2  one-cycle one-hot pulse; bit n means o_sin/o_cos belong to requester n.
- o_busy  out  1  high whenever the FSM is not in IDLE.

## Operation
Request capture:
- Each requester has a pending flag and a phase buffer.
- i_req[n]=1 sets pend[n] and loads buf[n] with i_phn.
- A strobe while pend[n] is already set overwrites buf[n]; the latest phase wins and no error is flagged.

Arbitration:
- Decided only in IDLE, among the pending flags. A lone pending requester wins.
- If both are pending, the requester selected by pointer `rr` wins. After every grant, `rr` points to the other requester.
- The grant clears pend[n], copies buf[n] into the working phase `ph` and latches the requester id.
- A strobe on the same cycle as the grant of that same requester re-sets pend[n] with the new phase. The grant still uses the old buffered phase.

FSM:
- IDLE: on a grant, o_lut_ph <= ph; go to ISSUE.
- ISSUE: o_lut_ph <= ph + COS_OFFSET, mod 2^PH_W with wrap (e.g. 0xC000 -> 0x0000); wait counter cleared; go to WAIT.
- WAIT: counter increments each cycle.
  - Sine captured from i_lut_sin at grant edge G + LUT_LAT + 1.
  - Cosine captured into o_cos at G + LUT_LAT + 2. At the same edge, o_valid[id] is set, o_sin is updated from the sine capture, and the FSM returns to IDLE.
- o_valid stays high for exactly one cycle.
- o_sin/o_cos hold their values until the next o_valid.

## Timing
- Reset values: o_lut_ph=0, o_sin=0, o_cos=0, o_valid=0, o_busy=0. Also cleared: pend, buf, `rr` (points to requester 0), counter, and state (IDLE).
- Latency: strobe edge S gives the earliest grant at S+1 and o_valid at S+1+LUT_LAT+2.
- Throughput: one pair per LUT_LAT+3 cycles. The FSM is back in IDLE in the o_valid cycle, so a pending request is granted at the following edge.
- o_sin and o_cos always change on the same edge as the o_valid pulse, never on any other edge.
- rst asserted mid-transaction: the transaction is dropped with no o_valid, and all state returns to reset values asynchronously. After release, the first grant occurs only for strobes that arrive after release.
- Arithmetic: the cosine address is an unsigned PH_W-bit sum with carry discarded. LUT samples pass through unmodified as signed DW.

## Structure
- Shared package `foc_pkg` holds PH_W, DW, COS_OFFSET, the requester-id type (1 bit) and the FSM state enum (IDLE, ISSUE, WAIT).
- Sub-module `rr_arb2` is the 2-way round-robin arbiter: inputs pend[1:0] and enable; outputs grant one-hot. It owns the `rr` pointer.
- The wait counter is sized to hold LUT_LAT+1.

## Test plan
Bench uses a behavioural LUT model with configurable LUT_LAT, a checker computing lut(ph) and lut(ph+0x4000), and a per-cycle o_valid/o_lut_ph scoreboard.
- Single request: i_req=01, i_ph0=0x0000, LUT_LAT=1.
  - o_lut_ph = 0x0000 then 0x4000 on consecutive cycles.
  - o_valid=01 exactly 4 cycles after the strobe, with o_sin=lut(0x0000) and o_cos=lut(0x4000).
- Wrap: i_req=10, i_ph1=0xC000.
  - Cosine address 0x0000; o_cos=lut(0x0000); o_valid=10.
- Simultaneous strobes i_req=11 right after reset (ph0=0x1000, ph1=0x2000).
  - Requester 0 served first, requester 1 exactly LUT_LAT+3 cycles later.
  - A repeat i_req=11 then serves requester 1 first.
- Overwrite while busy: strobe req0 (0x1000); during WAIT, strobe req1 twice (0x3000, then 0x5000).
  - The second transaction uses 0x5000 only.
  - Exactly two o_valid pulses in total.
- Reset mid-operation: assert rst during WAIT.
  - All outputs are 0 immediately and no o_valid follows.
  - A fresh request after release completes normally.
- LUT_LAT=4 sweep: phases 0x0000..0xFFFF in steps of 0x0400, alternating requesters.
  - Every pair matches the model.
  - o_valid spacing is ≥7 cycles.
  - o_sin/o_cos never change outside o_valid cycles.
